// File: rtl/phj_pkg.sv
`default_nettype none
// ============================================================================
// Package     : phj_pkg
// Description : Shared types and constants for the partitioned hash join
//               scatter stage (hashed tuples, packed lines, writer states).
// Revision    : 1.0 - initial release
// ============================================================================
package phj_pkg;

   localparam int KEY_W     = 32;
   localparam int PAYLOAD_W = 32;
   localparam int HASH_W    = 32;
   localparam int PART_W    = 4;
   localparam int NUM_PARTS = 1 << PART_W;
   localparam int TPL       = 8;                  // tuples per line
   localparam int SLOT_W    = 3;                  // log2(TPL)
   localparam int FILL_W    = 4;                  // holds 0..TPL
   localparam int TUPLE_W   = KEY_W + PAYLOAD_W;
   localparam int LINE_W    = TUPLE_W * TPL;

   typedef struct packed {
      logic [HASH_W-1:0]    hash;
      logic [PAYLOAD_W-1:0] payload;
      logic [KEY_W-1:0]     key;
   } hashed_tuple_t;

   typedef struct packed {
      logic [PAYLOAD_W-1:0] payload;
      logic [KEY_W-1:0]     key;
   } tuple_t;

   // slot i occupies bits [64i+63:64i]
   typedef tuple_t [TPL-1:0] line_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } wr_state_t;

   // partition selected by the low hash bits
   function automatic logic [PART_W-1:0] part_of(input hashed_tuple_t t);
      return t.hash[PART_W-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/partition_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : partition_line_buf
// Description : Per-partition line buffers (NUM_PARTS x TPL tuples) with fill
//               counters. One write port, one read-and-clear port. The read
//               view folds in a same-cycle write to the same partition and
//               zeroes slots beyond the fill level.
// Revision    : 1.0 - initial release
// ============================================================================
module partition_line_buf
   import phj_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en_i,
   input  logic [PART_W-1:0] wr_part_i,
   input  tuple_t            wr_tuple_i,
   input  logic [PART_W-1:0] rd_part_i,
   input  logic              clr_en_i,
   output line_t             rd_line_o,
   output logic [FILL_W-1:0] rd_fill_o,
   output logic              wr_full_o
);

   tuple_t            mem_q  [NUM_PARTS][TPL];
   logic [FILL_W-1:0] fill_q [NUM_PARTS];

   logic [FILL_W-1:0] w_wr_fill;
   logic [FILL_W-1:0] w_rd_fill;
   logic              w_merge;

   assign w_wr_fill = fill_q[wr_part_i];
   assign w_rd_fill = fill_q[rd_part_i];
   assign w_merge   = wr_en_i && (wr_part_i == rd_part_i);
   // the incoming tuple is the last slot of its line
   assign wr_full_o = wr_en_i && (w_wr_fill == FILL_W'(TPL - 1));
   assign rd_fill_o = w_rd_fill + FILL_W'(w_merge);

   // tuple storage; left unreset because the fill counters define validity
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_part_i][w_wr_fill[SLOT_W-1:0]] <= wr_tuple_i;
      end
   end

   // fill counters: clear wins over a same-cycle write (that tuple leaves in the line)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < NUM_PARTS; p++) begin
            fill_q[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_PARTS; p++) begin
            if (clr_en_i && (rd_part_i == PART_W'(p))) begin
               fill_q[p] <= '0;
            end else if (wr_en_i && (wr_part_i == PART_W'(p))) begin
               fill_q[p] <= fill_q[p] + FILL_W'(1);
            end
         end
      end
   end

   // read view: stored slots, then the bypassed write, unused slots zero
   always_comb begin
      rd_line_o = '0;
      for (int i = 0; i < TPL; i++) begin
         if (FILL_W'(i) < w_rd_fill) begin
            rd_line_o[i] = mem_q[rd_part_i][i];
         end else if (w_merge && (FILL_W'(i) == w_rd_fill)) begin
            rd_line_o[i] = wr_tuple_i;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/partition_writer.sv
`default_nettype none
// ============================================================================
// Module      : partition_writer
// Description : Scatter stage of the partitioned hash join. Packs hashed
//               tuples into per-partition 512-bit lines, emits full lines with
//               partition and line address, drains partial lines on flush and
//               flags lines dropped for lack of region space.
// Revision    : 1.0 - initial release
// ============================================================================
module partition_writer
   import phj_pkg::*;
#(
   parameter int KEY_BITS        = 32,
   parameter int PAYLOAD_BITS    = 32,
   parameter int HASH_BITS       = 32,
   parameter int PART_BITS       = 4,
   parameter int TUPLES_PER_LINE = 8,
   parameter int PART_LINES      = 1024,
   parameter int ADDR_BITS       = 32
)(
   input  logic                                             clk,
   input  logic                                             reset,
   input  logic                                             in_valid,
   input  logic [HASH_BITS+PAYLOAD_BITS+KEY_BITS-1:0]       in_data,
   output logic                                             ready_4_input,
   input  logic                                             flush_req,
   output logic                                             flush_done,
   output logic                                             out_valid,
   input  logic                                             out_ready,
   output logic [(KEY_BITS+PAYLOAD_BITS)*TUPLES_PER_LINE-1:0] out_data,
   output logic [PART_BITS-1:0]                             out_part,
   output logic [ADDR_BITS-1:0]                             out_addr,
   output logic [3:0]                                       out_count,
   output logic                                             overflow
);

   localparam int LC_W = $clog2(PART_LINES + 1);

   wr_state_t         state_q, state_d;
   logic [PART_W-1:0] scan_q, scan_d;
   logic              live_q;
   logic [LC_W-1:0]   line_cnt_q [NUM_PARTS];
   logic              overflow_q;

   logic              out_valid_q;
   line_t             out_data_q;
   logic [PART_W-1:0] out_part_q;
   logic [ADDR_BITS-1:0] out_addr_q;
   logic [3:0]        out_count_q;

   hashed_tuple_t     w_in;
   tuple_t            w_tuple;
   logic [PART_W-1:0] w_in_part;
   logic              w_hash_unused;
   logic              w_out_free;
   logic              w_ready;
   logic              w_accept;
   logic [PART_W-1:0] w_rd_part;
   logic [LC_W-1:0]   w_sel_cnt;
   logic              w_region_full;
   logic [ADDR_BITS-1:0] w_line_addr;
   logic              w_wr_en;
   logic              w_clr_en;
   logic              w_load;
   logic              w_ovf_set;

   line_t             w_buf_line;
   logic [FILL_W-1:0] w_buf_fill;
   logic              w_buf_full;

   assign w_in          = in_data;
   assign w_tuple       = {w_in.payload, w_in.key};
   assign w_in_part     = part_of(w_in);
   assign w_hash_unused = ^w_in.hash[HASH_W-1:PART_W];

   assign w_out_free = !out_valid_q || out_ready;
   // live_q keeps ready low while reset is held and for the first cycle after
   assign w_ready    = live_q && (state_q == RUN) && w_out_free;
   assign w_accept   = in_valid && w_ready;

   assign w_rd_part     = (state_q == FLUSH) ? scan_q : w_in_part;
   assign w_sel_cnt     = line_cnt_q[w_rd_part];
   assign w_region_full = (w_sel_cnt == LC_W'(PART_LINES));
   assign w_line_addr   = ADDR_BITS'(w_rd_part) * ADDR_BITS'(PART_LINES)
                        + ADDR_BITS'(w_sel_cnt);

   partition_line_buf u_buf (
      .clk        (clk),
      .reset      (reset),
      .wr_en_i    (w_wr_en),
      .wr_part_i  (w_in_part),
      .wr_tuple_i (w_tuple),
      .rd_part_i  (w_rd_part),
      .clr_en_i   (w_clr_en),
      .rd_line_o  (w_buf_line),
      .rd_fill_o  (w_buf_fill),
      .wr_full_o  (w_buf_full)
   );

   // writer FSM state register and flush scan pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         scan_q  <= '0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         scan_q  <= scan_d;
         live_q  <= 1'b1;
      end
   end

   // next state plus buffer/emit control; a full region turns an emit into a drop
   always_comb begin
      state_d   = state_q;
      scan_d    = scan_q;
      w_wr_en   = 1'b0;
      w_clr_en  = 1'b0;
      w_load    = 1'b0;
      w_ovf_set = 1'b0;
      case (state_q)
         RUN: begin
            if (w_accept) begin
               w_wr_en = 1'b1;
               if (w_buf_full) begin
                  w_clr_en = 1'b1;
                  if (w_region_full) begin
                     w_ovf_set = 1'b1;
                  end else begin
                     w_load = 1'b1;
                  end
               end
            end
            if (flush_req) begin
               state_d = FLUSH;
               scan_d  = '0;
            end
         end
         FLUSH: begin
            if (w_out_free) begin
               if (w_buf_fill != '0) begin
                  w_clr_en = 1'b1;
                  if (w_region_full) begin
                     w_ovf_set = 1'b1;
                  end else begin
                     w_load = 1'b1;
                  end
               end
               if (scan_q == PART_W'(NUM_PARTS - 1)) begin
                  state_d = DONE;
               end else begin
                  scan_d = scan_q + PART_W'(1);
               end
            end
         end
         DONE: begin
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // per-partition line counters (saturate at PART_LINES) and sticky overflow
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < NUM_PARTS; p++) begin
            line_cnt_q[p] <= '0;
         end
         overflow_q <= 1'b0;
      end else begin
         for (int p = 0; p < NUM_PARTS; p++) begin
            if (w_load && (w_rd_part == PART_W'(p))) begin
               line_cnt_q[p] <= line_cnt_q[p] + LC_W'(1);
            end
         end
         if (w_ovf_set) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // output register: load on emit, otherwise hold until the consumer takes it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_part_q  <= '0;
         out_addr_q  <= '0;
         out_count_q <= '0;
      end else if (w_load) begin
         out_valid_q <= 1'b1;
         out_data_q  <= w_buf_line;
         out_part_q  <= w_rd_part;
         out_addr_q  <= w_line_addr;
         out_count_q <= w_buf_fill;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign ready_4_input = w_ready;
   assign flush_done    = (state_q == DONE);
   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign out_part      = out_part_q;
   assign out_addr      = out_addr_q;
   assign out_count     = out_count_q;
   assign overflow      = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_partition_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_partition_writer
// Description : Scoreboard bench for partition_writer. Main instance uses the
//               default region size; a second instance with PART_LINES=2
//               exercises region overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_partition_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         in_valid;
   logic [95:0]  in_data;
   logic         ready_4_input;
   logic         flush_req;
   logic         flush_done;
   logic         out_valid;
   logic         out_ready;
   logic [511:0] out_data;
   logic [3:0]   out_part;
   logic [31:0]  out_addr;
   logic [3:0]   out_count;
   logic         overflow;

   logic         in_valid2;
   logic [95:0]  in_data2;
   logic         ready2;
   logic         flush_req2;
   logic         flush_done2;
   logic         out_valid2;
   logic         out_ready2;
   logic [511:0] out_data2;
   logic [3:0]   out_part2;
   logic [31:0]  out_addr2;
   logic [3:0]   out_count2;
   logic         overflow2;

   int checks       = 0;
   int errors       = 0;
   int fd_pulses    = 0;
   int stall_cycles = 0;

   typedef struct {
      logic [511:0] data;
      logic [3:0]   part;
      logic [31:0]  addr;
      logic [3:0]   count;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp2_q[$];

   partition_writer dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .ready_4_input(ready_4_input), .flush_req(flush_req), .flush_done(flush_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_part(out_part), .out_addr(out_addr), .out_count(out_count),
      .overflow(overflow)
   );

   partition_writer #(.PART_LINES(2)) dut_ovf (
      .clk(clk), .reset(reset), .in_valid(in_valid2), .in_data(in_data2),
      .ready_4_input(ready2), .flush_req(flush_req2), .flush_done(flush_done2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
      .out_part(out_part2), .out_addr(out_addr2), .out_count(out_count2),
      .overflow(overflow2)
   );

   function automatic logic [31:0] pay(input logic [31:0] k);
      return 32'hC0DE0000 ^ k;
   endfunction

   // expected line: n tuples with keys base, base+step, ...; other slots zero
   function automatic logic [511:0] mk_line(input logic [31:0] base, input int n, input int step);
      logic [511:0] l;
      logic [31:0]  k;
      l = '0;
      for (int i = 0; i < n; i++) begin
         k = base + 32'(i * step);
         l[64*i +: 64] = {pay(k), k};
      end
      return l;
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_line(input bit second, input logic [511:0] d, input logic [3:0] p,
                              input logic [31:0] a, input logic [3:0] c);
      exp_t e;
      e.data = d; e.part = p; e.addr = a; e.count = c;
      if (second) exp2_q.push_back(e);
      else        exp_q.push_back(e);
   endtask

   // drive one tuple, waiting (bounded) for ready; returns at posedge+1
   task automatic send(input logic [3:0] p, input logic [31:0] k, input logic fl);
      int waits;
      in_valid  = 1'b1;
      in_data   = {28'hA5A5A5A, p, pay(k), k};
      flush_req = fl;
      waits = 0;
      @(negedge clk);
      while (!ready_4_input && waits < 200) begin
         waits++;
         @(negedge clk);
      end
      if (waits >= 200) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: ready_4_input=%0b required 1", ready_4_input);
      end
      stall_cycles += waits;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      flush_req = 1'b0;
   endtask

   // called at posedge+1 right after flush_req was taken
   task automatic wait_flush(input string tag);
      int n;
      bit rdy_hi;
      n = 0;
      rdy_hi = 1'b0;
      @(negedge clk);
      while (flush_done !== 1'b1 && n < 20) begin
         rdy_hi |= ready_4_input;
         n++;
         @(negedge clk);
      end
      rdy_hi |= ready_4_input;
      chk({tag, "_done_in_time"}, 512'(n <= 17), 512'(1));
      chk({tag, "_ready_low"}, 512'(rdy_hi), 512'(0));
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 512'(flush_done), 512'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk({tag, "_drained"}, 512'(exp_q.size()), 512'(0));
   endtask

   // monitor for the main instance: scoreboard pops and stall stability
   bit   hold_v = 1'b0;
   exp_t held;
   always @(negedge clk) begin
      if (reset) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            chk("stall_valid", 512'(out_valid), 512'(1));
            chk("stall_data",  out_data, held.data);
            chk("stall_part",  512'(out_part), 512'(held.part));
            chk("stall_addr",  512'(out_addr), 512'(held.addr));
            chk("stall_count", 512'(out_count), 512'(held.count));
         end
         if (flush_done) fd_pulses++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_line: got part %0d addr %0d count %0d, required no line",
                        out_part, out_addr, out_count);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("line_data",  out_data, e.data);
               chk("line_part",  512'(out_part), 512'(e.part));
               chk("line_addr",  512'(out_addr), 512'(e.addr));
               chk("line_count", 512'(out_count), 512'(e.count));
            end
         end
         hold_v     = out_valid && !out_ready;
         held.data  = out_data;
         held.part  = out_part;
         held.addr  = out_addr;
         held.count = out_count;
      end
   end

   // monitor for the overflow instance (always ready)
   always @(negedge clk) begin
      if (!reset && out_valid2 && out_ready2) begin
         if (exp2_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ovf_unexpected_line: got part %0d addr %0d count %0d, required no line",
                     out_part2, out_addr2, out_count2);
         end else begin
            exp_t e;
            e = exp2_q.pop_front();
            chk("ovf_line_data",  out_data2, e.data);
            chk("ovf_line_part",  512'(out_part2), 512'(e.part));
            chk("ovf_line_addr",  512'(out_addr2), 512'(e.addr));
            chk("ovf_line_count", 512'(out_count2), 512'(e.count));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached before summary, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rdy2_low;
      reset = 1'b1; in_valid = 1'b0; in_data = '0; flush_req = 1'b0; out_ready = 1'b1;
      in_valid2 = 1'b0; in_data2 = '0; flush_req2 = 1'b0; out_ready2 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid",  512'(out_valid), 512'(0));
      chk("rst_out_data",   out_data, 512'(0));
      chk("rst_out_part",   512'(out_part), 512'(0));
      chk("rst_out_addr",   512'(out_addr), 512'(0));
      chk("rst_out_count",  512'(out_count), 512'(0));
      chk("rst_flush_done", 512'(flush_done), 512'(0));
      chk("rst_overflow",   512'(overflow), 512'(0));
      chk("rst_ready",      512'(ready_4_input), 512'(0));
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // one full line to partition 3
      stall_cycles = 0;
      expect_line(1'b0, mk_line(32'd1, 8, 1), 4'd3, 32'd3072, 4'd8);
      for (int i = 0; i < 8; i++) send(4'd3, 32'(i + 1), 1'b0);
      chk("t1_no_stall", 512'(stall_cycles), 512'(0));
      drain("t1");

      // interleaved partitions 0 and 1, back-to-back completions
      stall_cycles = 0;
      expect_line(1'b0, mk_line(32'h10, 8, 2), 4'd0, 32'd0,    4'd8);
      expect_line(1'b0, mk_line(32'h11, 8, 2), 4'd1, 32'd1024, 4'd8);
      for (int i = 0; i < 16; i++) send(4'(i % 2), 32'(32'h10 + i), 1'b0);
      chk("t2_no_stall", 512'(stall_cycles), 512'(0));
      drain("t2");

      // backpressure while a line waits and a second one is being filled
      out_ready = 1'b0;
      expect_line(1'b0, mk_line(32'h20, 8, 1), 4'd6, 32'd6144, 4'd8);
      expect_line(1'b0, mk_line(32'h30, 8, 1), 4'd7, 32'd7168, 4'd8);
      fork
         begin
            for (int i = 0; i < 8; i++) send(4'd6, 32'(32'h20 + i), 1'b0);
            for (int i = 0; i < 8; i++) send(4'd7, 32'(32'h30 + i), 1'b0);
         end
         begin
            int n;
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 100) begin
               n++;
               @(negedge clk);
            end
            chk("t3_line_held", 512'(out_valid), 512'(1));
            repeat (8) @(negedge clk);
            chk("t3_ready_low_on_stall", 512'(ready_4_input), 512'(0));
            chk("t3_no_early_drain", 512'(exp_q.size()), 512'(2));
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain("t3");

      // partial lines drained by flush; last tuple arrives with flush_req
      expect_line(1'b0, mk_line(32'h21, 1, 1), 4'd2, 32'd2048, 4'd1);
      expect_line(1'b0, mk_line(32'h51, 3, 1), 4'd5, 32'd5120, 4'd3);
      send(4'd5, 32'h51, 1'b0);
      send(4'd5, 32'h52, 1'b0);
      send(4'd5, 32'h53, 1'b0);
      send(4'd2, 32'h21, 1'b1);
      wait_flush("t4");
      drain("t4");

      // region overflow on the PART_LINES=2 instance
      expect_line(1'b1, mk_line(32'h100, 8, 1), 4'd0, 32'd0, 4'd8);
      expect_line(1'b1, mk_line(32'h108, 8, 1), 4'd0, 32'd1, 4'd8);
      rdy2_low = 0;
      for (int i = 0; i < 24; i++) begin
         in_valid2 = 1'b1;
         in_data2  = {28'h5A5A5A5, 4'h0, pay(32'(32'h100 + i)), 32'(32'h100 + i)};
         @(negedge clk);
         if (!ready2) rdy2_low++;
         if (i == 16) chk("t5_no_overflow_yet", 512'(overflow2), 512'(0));
         @(posedge clk);
         #1;
      end
      in_valid2 = 1'b0;
      chk("t5_ready_high", 512'(rdy2_low), 512'(0));
      chk("t5_overflow_set", 512'(overflow2), 512'(1));
      repeat (5) @(posedge clk);
      #1;
      chk("t5_overflow_sticky", 512'(overflow2), 512'(1));
      chk("t5_lines_seen", 512'(exp2_q.size()), 512'(0));

      // reset in the middle of a flush
      send(4'd4, 32'h41, 1'b0);
      send(4'd4, 32'h42, 1'b0);
      send(4'd9, 32'h91, 1'b0);
      flush_req = 1'b1;
      @(posedge clk);
      #1;
      flush_req = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_out_valid",  512'(out_valid), 512'(0));
      chk("t6_out_data",   out_data, 512'(0));
      chk("t6_out_part",   512'(out_part), 512'(0));
      chk("t6_out_addr",   512'(out_addr), 512'(0));
      chk("t6_out_count",  512'(out_count), 512'(0));
      chk("t6_flush_done", 512'(flush_done), 512'(0));
      chk("t6_ready",      512'(ready_4_input), 512'(0));
      chk("t6_overflow2_cleared", 512'(overflow2), 512'(0));
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      expect_line(1'b0, mk_line(32'h60, 8, 1), 4'd0, 32'd0, 4'd8);
      for (int i = 0; i < 8; i++) send(4'd0, 32'(32'h60 + i), 1'b0);
      drain("t6");
      // buffered tuples of the aborted flush are gone: this flush emits nothing
      flush_req = 1'b1;
      @(posedge clk);
      #1;
      flush_req = 1'b0;
      wait_flush("t6b");

      repeat (5) @(posedge clk);
      #1;
      chk("end_queue_empty",  512'(exp_q.size()), 512'(0));
      chk("end_queue2_empty", 512'(exp2_q.size()), 512'(0));
      chk("end_flush_pulses", 512'(fd_pulses), 512'(2));
      chk("end_ovf_no_flush", 512'(flush_done2), 512'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
